// File: rtl/digit_display_scheduler_if.sv
// Digit request / display-select bundle for digit_display_scheduler.
// Carries:
//   vsync                 frame timing from the display driver
//   req0_* / req1_*       valid/ready digit sources (recogniser, keypad override)
//   num, num_update       registered digit select and its load pulse
//   req_err, pending      out-of-range request pulse and pending-digit flag
// Modports: slave = the scheduler, master = whatever drives the requests.
interface digit_display_scheduler_if;
    logic       vsync;
    logic       req0_valid;
    logic [3:0] req0_num;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_num;
    logic       req1_ready;
    logic [4:0] num;
    logic       num_update;
    logic       req_err;
    logic       pending;

    modport slave (
        input  vsync,
        input  req0_valid,
        input  req0_num,
        output req0_ready,
        input  req1_valid,
        input  req1_num,
        output req1_ready,
        output num,
        output num_update,
        output req_err,
        output pending
    );

    modport master (
        output vsync,
        output req0_valid,
        output req0_num,
        input  req0_ready,
        output req1_valid,
        output req1_num,
        input  req1_ready,
        input  num,
        input  num_update,
        input  req_err,
        input  pending
    );
endinterface

// File: rtl/digit_display_scheduler.sv
// Frame-synchronous digit select scheduler.
// Arbitrates round-robin between two digit sources, holds one accepted digit and
// applies it to the display select only at a frame start, with each applied digit
// held for at least HOLD_FRAMES frames.
// Ports:
//   clk_i  pixel clock (shared with the display driver)
//   rst_i  asynchronous active-high reset
//   bus    digit_display_scheduler_if.slave (vsync, two request channels, outputs)
module digit_display_scheduler #(
    parameter int unsigned HOLD_FRAMES = 30,
    parameter bit          VSYNC_POL   = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    digit_display_scheduler_if.slave        bus
);

    localparam logic [7:0] HoldReload = 8'(HOLD_FRAMES - 1);

    typedef enum logic {StIdle, StPend} state_e;

    state_e     state_q, state_d;
    logic [3:0] pend_num_q, pend_num_d;
    logic [4:0] num_q, num_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       num_update_q, num_update_d;
    logic       req_err_q, req_err_d;
    logic       vsync_q;

    logic       vs_act;
    logic       frame_start;
    logic       both_valid;
    logic       gnt1;
    logic       ready0, ready1;
    logic       xfer0, xfer1;
    logic [3:0] xfer_num;

    assign vs_act      = ~(bus.vsync ^ VSYNC_POL);
    assign frame_start = vs_act & ~vsync_q;

    always_comb begin
        state_d      = state_q;
        pend_num_d   = pend_num_q;
        num_d        = num_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = last_grant_q;
        num_update_d = 1'b0;
        req_err_d    = 1'b0;

        // On a tie the grant goes to the source that did not win last time.
        both_valid = bus.req0_valid & bus.req1_valid;
        gnt1       = both_valid ? ~last_grant_q : bus.req1_valid;
        ready0     = (state_q == StIdle) & ~(both_valid & gnt1);
        ready1     = (state_q == StIdle) & ~(both_valid & ~gnt1);
        xfer0      = bus.req0_valid & ready0;
        xfer1      = bus.req1_valid & ready1;
        xfer_num   = xfer1 ? bus.req1_num : bus.req0_num;

        // The hold count runs down on every frame, whether or not a digit is waiting.
        if (frame_start) begin
            if (hold_cnt_q != 8'd0) begin
                hold_cnt_d = hold_cnt_q - 8'd1;
            end else if (state_q == StPend) begin
                num_d        = {1'b0, pend_num_q};
                hold_cnt_d   = HoldReload;
                num_update_d = 1'b1;
                state_d      = StIdle;
            end
        end

        // Transfers only happen in StIdle, so they never collide with an apply.
        unique case (state_q)
            StIdle: begin
                if (xfer0 | xfer1) begin
                    last_grant_d = xfer1;
                    if (xfer_num <= 4'd9) begin
                        pend_num_d = xfer_num;
                        state_d    = StPend;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            StPend: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pend_num_q   <= 4'd0;
            num_q        <= 5'd0;
            hold_cnt_q   <= 8'd0;
            last_grant_q <= 1'b1;
            num_update_q <= 1'b0;
            req_err_q    <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_num_q   <= pend_num_d;
            num_q        <= num_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            num_update_q <= num_update_d;
            req_err_q    <= req_err_d;
            vsync_q      <= vs_act;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.num        = num_q;
    assign bus.num_update = num_update_q;
    assign bus.req_err    = req_err_q;
    assign bus.pending    = (state_q == StPend);

endmodule

// File: tb/tb_digit_display_scheduler.sv
module tb_digit_display_scheduler;

    localparam int Hold = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    digit_display_scheduler_if bus ();

    digit_display_scheduler #(
        .HOLD_FRAMES(Hold),
        .VSYNC_POL  (1'b1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_num   = 4'd0;
        bus.req1_num   = 4'd0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.vsync = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.vsync = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Rising vsync for one cycle; returns at the negedge after the frame_start cycle.
    task automatic frame_edge();
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
    endtask

    // One-cycle request; readies sampled mid-cycle, returns at the following negedge.
    task automatic send(input logic v0, input logic [3:0] n0, input logic v1,
                        input logic [3:0] n1, output logic r0, output logic r1);
        bus.req0_valid = v0;
        bus.req0_num   = n0;
        bus.req1_valid = v1;
        bus.req1_num   = n1;
        #1;
        r0 = bus.req0_ready;
        r1 = bus.req1_ready;
        @(negedge clk);
        drive_idle();
    endtask

    // Reference model: a digit is eligible once at least Hold frames have passed
    // since the previous apply (or if nothing was applied since reset).
    int   m_num, m_pv, m_lastg, m_frame, m_last_apply;
    logic m_pend, m_upd, m_err, m_vprev, m_applied;

    function automatic void model_reset();
        m_num = 0; m_pv = 0; m_lastg = 1; m_frame = 0; m_last_apply = 0;
        m_pend = 0; m_upd = 0; m_err = 0; m_vprev = 0; m_applied = 0;
    endfunction

    function automatic int model_winner(input logic v0, input logic v1);
        if (v0 && v1) return (m_lastg == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    function automatic logic model_ready(input int s, input logic v0, input logic v1);
        if (m_pend) return 1'b0;
        if (v0 && v1) return model_winner(v0, v1) == s;
        return 1'b1;
    endfunction

    function automatic void model_step(input logic vs, input logic v0, input int n0,
                                       input logic v1, input int n1);
        logic fs, pend_before;
        int   g, val;
        fs          = vs && !m_vprev;
        m_vprev     = vs;
        m_upd       = 0;
        m_err       = 0;
        pend_before = m_pend;
        if (fs) begin
            m_frame++;
            if (pend_before && (!m_applied || (m_frame - m_last_apply) >= Hold)) begin
                m_num        = m_pv;
                m_pend       = 0;
                m_last_apply = m_frame;
                m_applied    = 1;
                m_upd        = 1;
            end
        end
        if (!pend_before && (v0 || v1)) begin
            g       = model_winner(v0, v1);
            m_lastg = g;
            val     = (g == 1) ? n1 : n0;
            if (val <= 9) begin
                m_pend = 1;
                m_pv   = val;
            end else begin
                m_err = 1;
            end
        end
    endfunction

    typedef struct {
        logic       v0;
        logic [3:0] n0;
        logic       v1;
        logic [3:0] n1;
        logic       r0;
        logic       r1;
        logic       pend;
        logic       err;
        logic [4:0] num;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic r0, r1;
        logic v0, v1, vs;
        logic [3:0] n0, n1;

        // From reset: last grant is source 1, so source 0 wins ties.
        vecs[0] = '{1'b1, 4'd7,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd7};
        vecs[1] = '{1'b0, 4'd0,  1'b1, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 5'd4};
        vecs[2] = '{1'b1, 4'd2,  1'b1, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 5'd2};
        vecs[3] = '{1'b1, 4'd12, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        vecs[4] = '{1'b0, 4'd0,  1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0};
        vecs[5] = '{1'b0, 4'd3,  1'b0, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[6] = '{1'b1, 4'd10, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
        vecs[7] = '{1'b1, 4'd9,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd9};

        rst       = 1'b1;
        bus.vsync = 1'b0;
        drive_idle();
        #1;
        chk("reset_num", bus.num, 0);
        chk("reset_pending", bus.pending, 0);
        chk("reset_num_update", bus.num_update, 0);
        chk("reset_req_err", bus.req_err, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            send(vecs[i].v0, vecs[i].n0, vecs[i].v1, vecs[i].n1, r0, r1);
            chk($sformatf("vec%0d_ready0", i), r0, vecs[i].r0);
            chk($sformatf("vec%0d_ready1", i), r1, vecs[i].r1);
            chk($sformatf("vec%0d_pending", i), bus.pending, vecs[i].pend);
            chk($sformatf("vec%0d_req_err", i), bus.req_err, vecs[i].err);
            idle(2);
            frame_edge();
            chk($sformatf("vec%0d_num", i), bus.num, vecs[i].num);
        end

        // First request after reset, then first frame applies it.
        do_reset();
        idle(10);
        send(1'b1, 4'd7, 1'b0, 4'd0, r0, r1);
        chk("first_ready0", r0, 1);
        chk("first_pending", bus.pending, 1);
        chk("first_num_before", bus.num, 0);
        idle(3);
        frame_edge();
        chk("first_num", bus.num, 7);
        chk("first_update", bus.num_update, 1);
        chk("first_pending_clr", bus.pending, 0);
        @(negedge clk);
        chk("first_update_drop", bus.num_update, 0);

        // Hold enforcement: 4 waits out frames F+1, F+2.
        send(1'b0, 4'd0, 1'b1, 4'd4, r0, r1);
        chk("hold_ready1", r1, 1);
        for (int f = 1; f <= 2; f++) begin
            idle(3);
            frame_edge();
            chk($sformatf("hold_f%0d_num", f), bus.num, 7);
            chk($sformatf("hold_f%0d_pending", f), bus.pending, 1);
            chk($sformatf("hold_f%0d_update", f), bus.num_update, 0);
        end
        idle(3);
        frame_edge();
        chk("hold_f3_num", bus.num, 4);
        chk("hold_f3_update", bus.num_update, 1);

        // Round-robin arbitration.
        do_reset();
        send(1'b1, 4'd2, 1'b1, 4'd5, r0, r1);
        chk("arb1_ready0", r0, 1);
        chk("arb1_ready1", r1, 0);
        idle(2);
        frame_edge();
        chk("arb1_num", bus.num, 2);
        for (int f = 0; f < Hold - 1; f++) begin
            idle(2);
            frame_edge();
        end
        send(1'b1, 4'd3, 1'b1, 4'd6, r0, r1);
        chk("arb2_ready0", r0, 0);
        chk("arb2_ready1", r1, 1);
        idle(2);
        frame_edge();
        chk("arb2_num", bus.num, 6);

        // Out-of-range value: handshake completes, dropped, single error pulse.
        send(1'b1, 4'd12, 1'b0, 4'd0, r0, r1);
        chk("bad_ready0", r0, 1);
        chk("bad_req_err", bus.req_err, 1);
        chk("bad_pending", bus.pending, 0);
        @(negedge clk);
        chk("bad_req_err_drop", bus.req_err, 0);
        chk("bad_num", bus.num, 6);

        // Transfer in the frame_start cycle with hold expired.
        for (int f = 0; f < Hold - 1; f++) begin
            idle(2);
            frame_edge();
        end
        idle(2);
        bus.vsync = 1'b1;
        send(1'b1, 4'd8, 1'b0, 4'd0, r0, r1);
        bus.vsync = 1'b0;
        chk("coinc_ready0", r0, 1);
        chk("coinc_num", bus.num, 6);
        chk("coinc_update", bus.num_update, 0);
        chk("coinc_pending", bus.pending, 1);
        idle(2);
        frame_edge();
        chk("coinc_next_num", bus.num, 8);

        // Async reset while a digit is pending.
        for (int f = 0; f < Hold - 1; f++) begin
            idle(2);
            frame_edge();
        end
        send(1'b1, 4'd4, 1'b0, 4'd0, r0, r1);
        idle(2);
        frame_edge();
        chk("ar_num4", bus.num, 4);
        send(1'b1, 4'd9, 1'b0, 4'd0, r0, r1);
        chk("ar_pending", bus.pending, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_num_zero", bus.num, 0);
        chk("ar_pending_zero", bus.pending, 0);
        chk("ar_ready0", bus.req0_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 4'd5, 1'b0, 4'd0, r0, r1);
        idle(2);
        frame_edge();
        chk("ar_after_num", bus.num, 5);

        // Randomized run against the frame-counting model.
        do_reset();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            chk("rnd_num", bus.num, 32'(m_num));
            chk("rnd_pending", bus.pending, m_pend);
            chk("rnd_update", bus.num_update, m_upd);
            chk("rnd_req_err", bus.req_err, m_err);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                drive_idle();
                bus.vsync = 1'b0;
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                continue;
            end
            v0 = ($urandom_range(0, 2) == 0);
            v1 = ($urandom_range(0, 2) == 0);
            n0 = 4'($urandom_range(0, 11));
            n1 = 4'($urandom_range(0, 11));
            vs = ($urandom_range(0, 5) == 0);
            bus.vsync      = vs;
            bus.req0_valid = v0;
            bus.req0_num   = n0;
            bus.req1_valid = v1;
            bus.req1_num   = n1;
            #1;
            chk("rnd_ready0", bus.req0_ready, model_ready(0, v0, v1));
            chk("rnd_ready1", bus.req1_ready, model_ready(1, v0, v1));
            model_step(vs, v0, int'(n0), v1, int'(n1));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_display_scheduler.md
Name: digit_display_scheduler

Overview:
- Sits in front of the digit-to-HDMI display path and drives its 5-bit digit select (`num`).
- Arbitrates between two digit sources:
  - req0: recogniser/classifier result.
  - req1: manual/keypad override.
- Holds one accepted request pending. Applies it only at a frame start, so a digit never changes mid-frame and no tearing occurs.
- Enforces a minimum display time per digit, counted in frames.

Parameters:
- HOLD_FRAMES, 30, minimum number of frames each applied digit stays displayed. Legal range 1..255.
- VSYNC_POL, 1, active level of `vsync`. 1 = active-high, 0 = active-low.

Ports:
- clk  in  1  pixel clock; same clock as the display driver.
- Rst  in  1  asynchronous, active-high reset.
- vsync  in  1  vertical sync from the display driver, synchronous to clk.
- req0_valid  in  1  source 0 has a digit.
- req0_num  in  4  source 0 digit value.
- req0_ready  out  1  source 0 handshake accept.
- req1_valid  in  1  source 1 has a digit.
- req1_num  in  4  source 1 digit value.
- req1_ready  out  1  source 1 handshake accept.
- num  out  5  registered digit select to the display path. Values 0..9 only.
- num_update  out  1  one-cycle pulse in the cycle after `num` changes value/loads.
- req_err  out  1  one-cycle pulse when an accepted request carried a value > 9.
- pending  out  1  a digit is accepted and waiting to be applied.

Behaviour:
- Reset (async, Rst=1) values:
  - num=0, num_update=0, req_err=0, pending=0.
  - hold_cnt=0 (8-bit), last_grant=1 (so req0 wins the first tie), vsync_d=inactive level.
- Frame start detection:
  - vs_act = vsync XNOR VSYNC_POL.
  - vsync_d <= vs_act each clk.
  - frame_start = vs_act & ~vsync_d: a single-cycle pulse on the inactive-to-active edge.
- Ready signals:
  - reqN_ready = ~pending (combinational).
  - A transfer occurs when reqN_valid & reqN_ready.
  - When both sources are valid, only the granted source sees ready high that cycle; the other's ready is forced 0.
- Arbitration:
  - Round-robin: when both are valid, grant the source ≠ last_grant.
  - last_grant updates on every transfer.
  - A single valid source is granted immediately.
- Acceptance:
  - If the granted num ≤ 9: pend_num <= value, pending <= 1 next cycle.
  - If the granted num > 9: the transfer still completes, the value is dropped, pending stays 0, and req_err pulses the next cycle.
- State machine (two states):
  - IDLE (pending=0): accept requests.
  - PEND (pending=1): ready low; wait for frame_start.
- On frame_start:
  - If hold_cnt ≠ 0: hold_cnt <= hold_cnt-1. No apply.
  - Else if PEND:
    - num <= {1'b0, pend_num}.
    - hold_cnt <= HOLD_FRAMES-1.
    - pending <= 0 (return to IDLE).
    - num_update pulses the next cycle.
  - Else (IDLE, hold_cnt=0): no change.
- Result: a digit applied at frame F is shown for frames F..F+HOLD_FRAMES-1. The earliest next apply is at frame F+HOLD_FRAMES.
- Simultaneous events:
  - A transfer in the same cycle as frame_start is not applied at that frame start. It becomes pending and waits for the next eligible frame start.
  - Apply and release occur in the same cycle. New requests can be accepted from the following cycle.
- Re-applying the same digit still reloads hold_cnt and pulses num_update.
- num is a register and never glitches. It changes only in the cycle following a frame_start.
- Reset mid-operation:
  - Discards the pending digit and clears the hold count.
  - num returns to 0 immediately (asynchronously).
- Latency: from an accepted request to `num` valid is 1 clk minimum, after the first eligible frame_start.

Test Plan:
- Reset release, HOLD_FRAMES=3:
  - req0 sends 7 at cycle 10 → req0_ready=1 at cycle 10, pending=1 from cycle 11.
  - First vsync rising edge → num=7 and a num_update pulse one cycle after frame_start.
- Hold enforcement, HOLD_FRAMES=3:
  - After 7 is applied at frame F, req1 sends 4 immediately.
  - Frames F+1 and F+2 → num stays 7, pending=1.
  - Frame F+3 → num=4.
- Arbitration:
  - Both valid after reset with req0=2, req1=5 → req0 granted (num 2 pending), req1_ready=0.
  - After the apply, both valid again with 3/6 → req1 granted (6).
- Invalid value: req0 sends 12 → handshake completes, req_err pulses once, pending=0, num unchanged.
- Edge coincidence: transfer of 8 in the exact frame_start cycle while hold_cnt=0 → num unchanged at that frame; num=8 at the next frame_start.
- Async reset: assert Rst mid-PEND with num=4 and pend_num=9 → num=0, pending=0, ready=1 immediately. After release, the first request is applied at the next frame start (hold_cnt=0).
